decode_level_stream: RTL
========================

# decode_level_stream

Parametrised, streaming single-level decoder for NTRU Prime mixed-radix R/q decoding. It takes one element per step from an upper-level value stream and merges 0..NBMAX little-endian bytes from the encoded byte stream into it. A pipelined Barrett divider then splits the result into remainder and quotient by a runtime modulus. One instance serves one recursion level; a chain of instances, or one instance reused with per-level configuration, forms a full Rq/Rounded decoder. Unlike the fixed-schedule decoder, every input and output uses valid/ready handshakes, so levels can be cascaded with backpressure.

## Interface
- RW, 14: width of element values (input r, output rem/q).
- NBMAX, 2: maximum bytes merged per element.
- XW, RW+8*NBMAX: width of the assembled value x and Barrett shift K.
- CW, 10: width of element counter.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_*; ignored while busy.
- cfg_m  in  RW  modulus M, 2 ≤ M < 2^RW.
- cfg_minv  in  XW+1  floor(2^XW / M).
- cfg_count  in  CW  number of input elements, ≥1.
- cfg_nb  in  2  bytes merged per non-final element, ≤ NBMAX.
- cfg_last_nb  in  2  bytes merged for final element, ≤ NBMAX.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the last output handshake.
- r_valid / r_ready / r_data  in/out/in  1/1/RW  upper-level element stream.
- b_valid / b_ready / b_data  in/out/in  1/1/8  encoded byte stream.
- o_valid / o_ready / o_data / o_last  out/in/out/out  1/1/RW/1  decoded output stream.
- err  out  1  sticky range-error flag (see Configuration).

## Operation
- FSM: IDLE → FETCH_R → FETCH_B → ISSUE → (FETCH_R | DRAIN) → DONE → IDLE.
- IDLE: all ready signals low. start latches config, clears element counter and err, and enters FETCH_R.
- FETCH_R: r_ready=1. On handshake, r is loaded into the x register. The byte count n is cfg_last_nb for the final element and cfg_nb otherwise. If n=0, go to ISSUE; otherwise go to FETCH_B.
- FETCH_B: b_ready=1. Byte j (j=0 first) is placed as x = (r << 8n) | Σ b_j << 8j. Go to ISSUE after n bytes are accepted.
- ISSUE: x enters the divider pipeline. Increment the element counter. If the counter reaches cfg_count, go to DRAIN; otherwise go to FETCH_R.
- Divider: prod = x·minv; q̂ = prod >> XW; rem̂ = x − q̂·M. Apply up to 2 conditional corrections (rem̂ ≥ M → rem̂ −= M, q̂ += 1). The result is exact for x < 2^XW.
- Output serializer emits rem, then q[RW-1:0], each as a separate beat.
- Odd tail: if cfg_count is odd, the final element's x is emitted as a single beat x[RW-1:0] with no split, and o_last=1.
- Even count: o_last=1 on the q beat of the final element.
- DRAIN: wait until the pipeline and serializer are empty, then go to DONE. DONE asserts done for 1 cycle, then returns to IDLE.
- Backpressure: when o_valid && !o_ready, the whole divider pipeline and serializer hold. The front end stops issuing once the pipeline is full, and o_data remains stable.
- Reset at any time: FSM returns to IDLE, and the pipeline and config are cleared.

## Timing
- Reset values: busy=0, done=0, r_ready=0, b_ready=0, o_valid=0, o_data=0, o_last=0, err=0.
- Pipeline stages: S0 x register, S1 product, S2 q̂/rem̂, S3 corrected output register.
- Latency: o_valid rises 4 cycles after the handshake that completes x (last byte, or r if n=0). With the output unstalled, the q beat follows on the next cycle.
- Throughput: one element per max(2, n+2) cycles with o_ready held high.
- r and b handshakes are never both active in the same cycle.
- done is asserted 1 cycle after the final output handshake. busy deasserts in the same cycle.
- Simultaneous start and rst_n low: reset wins.

## Configuration
- DECODE_LEVEL_RANGE_CHECK_EN defined: on each split, err is set when the full quotient satisfies q ≥ cfg_m_next. cfg_m_next is an extra RW-bit input latched at start. err is sticky until the next start or reset, and the data path is unaffected.
- Not defined: the cfg_m_next port is absent, err is tied to 0, and the range-check logic is omitted.

## Test plan
- Basic split: RW=14, NBMAX=2, M=4591, minv=233879, count=2, nb=1, last_nb=1. Input r=291 with byte 0x45, then r=0 with byte 0x00. Required output: 1109, 16, 0, 0, with o_last on the 4th beat, and o_valid 4 cycles after byte 0x45 is accepted.
- Max value / truncation: r=0x3FFF with bytes FF,FF and M=4591. Required output: 3334, then 4503 (233879 mod 2^14). With the macro and m_next=4591, err=1.
- Odd tail: count=3, last_nb=0, final r=1234. Required output: 2 split pairs, then a single beat 1234 with o_last=1. done pulses 1 cycle after that beat.
- Backpressure: hold o_ready=0 for 10 cycles during output of the basic-split case. Required: o_data stays stable, no beats are lost or duplicated, and the sequence is identical to the basic-split output.
- nb=0, M=2, minv=2^29 (XW=30), r=5. Required output: 1, 2. No b_ready is ever asserted.
- Reset mid-operation: drop rst_n during FETCH_B. Required: all outputs return to their reset values immediately. A new start then produces the correct basic-split output.

Source files
------------

// File: rtl/decode_level_stream.sv
// decode_level_stream: one streaming level of an NTRU Prime R/q decoder.
// Each upper-level element r is merged with 0..NBMAX little-endian bytes to
// form x, which a four-stage Barrett divider splits into (x mod M, x div M).
// The results leave as two beats, rem then q, except the odd tail element,
// which leaves as a single unsplit beat.
// Optional feature: define DECODE_LEVEL_RANGE_CHECK_EN to add the cfg_m_next
// port and a sticky err flag that is raised when a quotient is out of range.
module decode_level_stream #(
   parameter int RW    = 14,
   parameter int NBMAX = 2,
   parameter int XW    = RW + 8 * NBMAX,
   parameter int CW    = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [RW-1:0] cfg_m,
   input  logic [XW:0]   cfg_minv,
   input  logic [CW-1:0] cfg_count,
   input  logic [1:0]    cfg_nb,
   input  logic [1:0]    cfg_last_nb,
`ifdef DECODE_LEVEL_RANGE_CHECK_EN
   input  logic [RW-1:0] cfg_m_next,
`endif
   output logic          busy,
   output logic          done,
   input  logic          r_valid,
   output logic          r_ready,
   input  logic [RW-1:0] r_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [7:0]    b_data,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [RW-1:0] o_data,
   output logic          o_last,
   output logic          err
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH_R = 3'd1,
      FETCH_B = 3'd2,
      ISSUE   = 3'd3,
      DRAIN   = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t        r_state;
   logic [RW-1:0] r_cfgM;
   logic [XW:0]   r_cfgMinv;
   logic [CW-1:0] r_cfgCount;
   logic [1:0]    r_cfgNb;
   logic [1:0]    r_cfgLastNb;
   logic [CW-1:0] r_cnt;
   logic [XW-1:0] r_x;
   logic [1:0]    r_nByte;
   logic [1:0]    r_byteIdx;
   logic          r_busy;
   logic          r_done;
   logic          r_rReady;
   logic          r_bReady;

   // Divider pipeline: S1 product, S2 estimate, S3 corrected result
   logic          r_s1Valid;
   logic [XW-1:0] r_s1X;
   logic [2*XW:0] r_s1Prod;
   logic          r_s1Final;
   logic          r_s1Tail;
   logic          r_s2Valid;
   logic [XW-1:0] r_s2QHat;
   logic [XW-1:0] r_s2RemHat;
   logic [RW-1:0] r_s2XLow;
   logic          r_s2Final;
   logic          r_s2Tail;
   logic          r_s3Valid;
   logic [RW-1:0] r_s3Rem;
   logic [RW-1:0] r_s3Q;
   logic [RW-1:0] r_s3XLow;
   logic          r_s3Final;
   logic          r_s3Tail;
   logic          r_s3Phase;
   logic          r_err;

   logic [CW-1:0] w_cntNext;
   logic          w_isFinal;
   logic [1:0]    w_nSel;
   logic          w_rHs;
   logic          w_bHs;
   logic [XW-1:0] w_rShift;
   logic [XW-1:0] w_bShift;
   logic          w_finalBeat;
   logic          w_adv;
   logic          w_issue;
   logic          w_outHs;
   logic [2*XW:0] w_prod;
   logic [XW-1:0] w_mExt;
   logic [XW-1:0] w_qHat;
   logic [XW-1:0] w_qM;
   logic [XW-1:0] w_remHat;
   logic [XW-1:0] w_rem1;
   logic [XW-1:0] w_q1;
   logic [XW-1:0] w_rem2;
   logic [XW-1:0] w_q2;
   logic          w_unusedBits;

   assign w_cntNext = r_cnt + CW'(1);
   assign w_isFinal = (w_cntNext == r_cfgCount);
   assign w_nSel    = w_isFinal ? r_cfgLastNb : r_cfgNb;
   assign w_rHs     = r_valid & r_rReady;
   assign w_bHs     = b_valid & r_bReady;
   assign w_rShift  = {{(XW-RW){1'b0}}, r_data} << {w_nSel, 3'b000};
   assign w_bShift  = {{(XW-8){1'b0}}, b_data} << {r_byteIdx, 3'b000};

   // The pipeline moves only when S3 is empty or is handing off its final beat
   assign w_finalBeat = r_s3Tail | r_s3Phase;
   assign w_adv       = ~r_s3Valid | (o_ready & w_finalBeat);
   assign w_issue     = (r_state == ISSUE) & w_adv;
   assign w_outHs     = r_s3Valid & o_ready;

   assign w_prod   = {{(XW+1){1'b0}}, r_x} * {{XW{1'b0}}, r_cfgMinv};
   assign w_mExt   = {{(XW-RW){1'b0}}, r_cfgM};
   assign w_qHat   = r_s1Prod[2*XW-1:XW];
   assign w_qM     = w_qHat * w_mExt;
   assign w_remHat = r_s1X - w_qM;

   // The Barrett estimate undershoots by at most two, so two correction steps finish it
   always_comb begin
      w_rem1 = r_s2RemHat;
      w_q1   = r_s2QHat;
      if (r_s2RemHat >= w_mExt) begin
         w_rem1 = r_s2RemHat - w_mExt;
         w_q1   = r_s2QHat + XW'(1);
      end
      w_rem2 = w_rem1;
      w_q2   = w_q1;
      if (w_rem1 >= w_mExt) begin
         w_rem2 = w_rem1 - w_mExt;
         w_q2   = w_q1 + XW'(1);
      end
   end

   assign w_unusedBits = ^{r_s1Prod[2*XW], r_s1Prod[XW-1:0], w_rem2[XW-1:RW], w_q2[XW-1:RW]};

`ifdef DECODE_LEVEL_RANGE_CHECK_EN
   logic [RW-1:0] r_cfgMNext;

   // Latch the next-level modulus with the rest of the configuration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cfgMNext <= '0;
      end else if (start && (r_state == IDLE)) begin
         r_cfgMNext <= cfg_m_next;
      end
   end

   // Sticky flag for any split whose full quotient cannot be a next-level element
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err <= 1'b0;
      end else if (start && (r_state == IDLE)) begin
         r_err <= 1'b0;
      end else if (w_adv && r_s2Valid && !r_s2Tail &&
                   (w_q2 >= {{(XW-RW){1'b0}}, r_cfgMNext})) begin
         r_err <= 1'b1;
      end
   end
`else
   assign r_err = 1'b0;
`endif

   // Control FSM: element fetch, byte merge, issue into the divider, and completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cfgM      <= '0;
         r_cfgMinv   <= '0;
         r_cfgCount  <= '0;
         r_cfgNb     <= '0;
         r_cfgLastNb <= '0;
         r_cnt       <= '0;
         r_x         <= '0;
         r_nByte     <= '0;
         r_byteIdx   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_rReady    <= 1'b0;
         r_bReady    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_cfgM      <= cfg_m;
                  r_cfgMinv   <= cfg_minv;
                  r_cfgCount  <= cfg_count;
                  r_cfgNb     <= cfg_nb;
                  r_cfgLastNb <= cfg_last_nb;
                  r_cnt       <= '0;
                  r_busy      <= 1'b1;
                  r_rReady    <= 1'b1;
                  r_state     <= FETCH_R;
               end
            end
            FETCH_R: begin
               if (w_rHs) begin
                  r_x       <= w_rShift;
                  r_nByte   <= w_nSel;
                  r_byteIdx <= '0;
                  r_rReady  <= 1'b0;
                  if (w_nSel == 2'd0) begin
                     r_state <= ISSUE;
                  end else begin
                     r_bReady <= 1'b1;
                     r_state  <= FETCH_B;
                  end
               end
            end
            FETCH_B: begin
               if (w_bHs) begin
                  r_x       <= r_x | w_bShift;
                  r_byteIdx <= r_byteIdx + 2'd1;
                  if ((r_byteIdx + 2'd1) == r_nByte) begin
                     r_bReady <= 1'b0;
                     r_state  <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               if (w_adv) begin
                  r_cnt <= w_cntNext;
                  if (w_isFinal) begin
                     r_state <= DRAIN;
                  end else begin
                     r_rReady <= 1'b1;
                     r_state  <= FETCH_R;
                  end
               end
            end
            DRAIN: begin
               if (w_outHs && w_finalBeat && r_s3Final) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Divider stages and output serializer, all frozen together while w_adv is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid  <= 1'b0;
         r_s1X      <= '0;
         r_s1Prod   <= '0;
         r_s1Final  <= 1'b0;
         r_s1Tail   <= 1'b0;
         r_s2Valid  <= 1'b0;
         r_s2QHat   <= '0;
         r_s2RemHat <= '0;
         r_s2XLow   <= '0;
         r_s2Final  <= 1'b0;
         r_s2Tail   <= 1'b0;
         r_s3Valid  <= 1'b0;
         r_s3Rem    <= '0;
         r_s3Q      <= '0;
         r_s3XLow   <= '0;
         r_s3Final  <= 1'b0;
         r_s3Tail   <= 1'b0;
         r_s3Phase  <= 1'b0;
      end else if (w_adv) begin
         r_s1Valid  <= w_issue;
         r_s1X      <= r_x;
         r_s1Prod   <= w_prod;
         r_s1Final  <= w_isFinal;
         r_s1Tail   <= w_isFinal & r_cfgCount[0];
         r_s2Valid  <= r_s1Valid;
         r_s2QHat   <= w_qHat;
         r_s2RemHat <= w_remHat;
         r_s2XLow   <= r_s1X[RW-1:0];
         r_s2Final  <= r_s1Final;
         r_s2Tail   <= r_s1Tail;
         r_s3Valid  <= r_s2Valid;
         r_s3Rem    <= w_rem2[RW-1:0];
         r_s3Q      <= w_q2[RW-1:0];
         r_s3XLow   <= r_s2XLow;
         r_s3Final  <= r_s2Final;
         r_s3Tail   <= r_s2Tail;
         r_s3Phase  <= 1'b0;
      end else if (w_outHs) begin
         r_s3Phase <= 1'b1;
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign r_ready = r_rReady;
   assign b_ready = r_bReady;
   assign o_valid = r_s3Valid;
   assign o_data  = r_s3Tail ? r_s3XLow : (r_s3Phase ? r_s3Q : r_s3Rem);
   assign o_last  = r_s3Valid & r_s3Final & w_finalBeat;
   assign err     = r_err;

endmodule
